// File: rtl/wfg_spi_rx.sv
// SPI target receiver: oversamples sclk/cs_n/sdo in io_wbs_clk, deserialises 8/16/24/32-bit words.
// Ports: io_wbs_clk/io_wbs_rst, spi_* lines, cfg_* frame config, data_o/valid_o/ready_i, overflow_o/frame_err_o/busy_o.
module wfg_spi_rx #(
  parameter int MAXW        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            io_wbs_clk,
  input  logic            io_wbs_rst,
  input  logic            spi_sclk_i,
  input  logic            spi_cs_ni,
  input  logic            spi_sdo_i,
  input  logic            cfg_cpol_i,
  input  logic            cfg_cpha_i,
  input  logic            cfg_lsbfirst_i,
  input  logic [1:0]      cfg_dff_i,
  output logic [MAXW-1:0] data_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic            overflow_o,
  output logic            frame_err_o,
  output logic            busy_o
);

  localparam int CW = 6;
  localparam int IW = $clog2(MAXW);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sdo_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;
  logic [SYNC_STAGES:0]   settle_q;
  logic                   armed_q;

  state_t          state_q;
  logic            cpol_q;
  logic            cpha_q;
  logic            lsb_q;
  logic [1:0]      dff_q;
  logic [MAXW-1:0] sr_q;
  logic [CW-1:0]   cnt_q;
  logic [MAXW-1:0] data_q;
  logic            valid_q;
  logic            ovf_q;
  logic            ferr_q;

  logic            sclk_s, cs_s, sdo_s;
  logic            sclk_rise, sclk_fall;
  logic            cs_fall, cs_rise;
  logic            lead, trail, samp;
  logic            last;
  logic [MAXW-1:0] sr_d;

  always_ff @(posedge io_wbs_clk or posedge io_wbs_rst) begin
    if (io_wbs_rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      sdo_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      settle_q    <= '0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_ni};
      sdo_sync_q  <= {sdo_sync_q[SYNC_STAGES-2:0], spi_sdo_i};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      settle_q    <= {settle_q[SYNC_STAGES-1:0], 1'b1};
      // Arm only once the chains hold real line state and cs_n is seen
      // high, so a cs_n held low across reset never looks like a new frame.
      armed_q     <= armed_q | (settle_q[SYNC_STAGES] & cs_s);
    end
  end

  always_comb begin
    sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    cs_s      = cs_sync_q[SYNC_STAGES-1];
    sdo_s     = sdo_sync_q[SYNC_STAGES-1];
    sclk_rise = sclk_s & ~sclk_prev_q;
    sclk_fall = ~sclk_s & sclk_prev_q;
    cs_fall   = armed_q & ~cs_s & cs_prev_q;
    cs_rise   = cs_s & ~cs_prev_q;
    lead      = cpol_q ? sclk_fall : sclk_rise;
    trail     = cpol_q ? sclk_rise : sclk_fall;
    samp      = (state_q == SHIFT) & (cpha_q ? trail : lead);
    last      = (cnt_q == {1'b0, dff_q, 3'b111});
    sr_d      = sr_q;
    if (lsb_q) sr_d[cnt_q[IW-1:0]] = sdo_s;
    else       sr_d = {sr_q[MAXW-2:0], sdo_s};
  end

  always_ff @(posedge io_wbs_clk or posedge io_wbs_rst) begin
    if (io_wbs_rst) begin
      state_q <= IDLE;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      dff_q   <= 2'd0;
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
      if (valid_q & ready_i) valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q <= SHIFT;
            cpol_q  <= cfg_cpol_i;
            cpha_q  <= cfg_cpha_i;
            lsb_q   <= cfg_lsbfirst_i;
            dff_q   <= cfg_dff_i;
            sr_q    <= '0;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state_q <= IDLE;
            if (cnt_q != '0) ferr_q <= 1'b1;
            cnt_q <= '0;
            sr_q  <= '0;
          end else if (samp) begin
            if (last) begin
              cnt_q <= '0;
              sr_q  <= '0;
              // A word arriving while the consumer is taking the old one
              // replaces it; otherwise a full holding reg drops it.
              if (!valid_q || ready_i) begin
                data_q  <= sr_d;
                valid_q <= 1'b1;
              end else begin
                ovf_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 6'd1;
              sr_q  <= sr_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign overflow_o  = ovf_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q == SHIFT);

endmodule

// File: tb/tb_wfg_spi_rx.sv
// Testbench for wfg_spi_rx: directed scenarios plus randomised frames,
// scoreboard of expected words consumed by a handshake monitor.
module tb_wfg_spi_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk, cs_n, sdo;
  logic        cpol, cpha, lsb;
  logic [1:0]  dff;
  logic [31:0] data;
  logic        valid, ready, ovf, ferr, busy;

  wfg_spi_rx #(.MAXW(32), .SYNC_STAGES(2)) dut (
    .io_wbs_clk    (clk),
    .io_wbs_rst    (rst),
    .spi_sclk_i    (sclk),
    .spi_cs_ni     (cs_n),
    .spi_sdo_i     (sdo),
    .cfg_cpol_i    (cpol),
    .cfg_cpha_i    (cpha),
    .cfg_lsbfirst_i(lsb),
    .cfg_dff_i     (dff),
    .data_o        (data),
    .valid_o       (valid),
    .ready_i       (ready),
    .overflow_o    (ovf),
    .frame_err_o   (ferr),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int          ovf_seen = 0;
  int          ferr_seen = 0;
  int          pops = 0;
  int          rise_cyc = -1;
  int          last_samp = 0;
  bit          t_cpol, t_cpha, t_lsb;
  bit [1:0]    t_dff;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic int nbits(input bit [1:0] d);
    return 8 * (int'(d) + 1);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] w,
                                             input int n);
    logic [63:0] m;
    m = 64'(w) % (64'd1 << n);
    return m[31:0];
  endfunction

  initial begin
    logic pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (ovf === 1'b1) ovf_seen++;
      if (ferr === 1'b1) ferr_seen++;
      if (valid === 1'b1 && !pv) rise_cyc = cyc;
      pv = valid;
      if (!rst && valid === 1'b1 && ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected none", data);
        end else begin
          chk("word", data, exp_q.pop_front());
          pops++;
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic cfg_apply();
    cpol = t_cpol;
    cpha = t_cpha;
    lsb  = t_lsb;
    dff  = t_dff;
    sclk = t_cpol;
    wait_clk(6);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high();
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic send_bits(input logic [31:0] w, input int nb,
                           input int nsend, input bit rdy_pulse);
    for (int i = 0; i < nsend; i++) begin
      logic b;
      b = t_lsb ? w[i] : w[nb-1-i];
      if (!t_cpha) begin
        sdo = b;
        wait_clk(4);
        sclk = ~t_cpol;
        last_samp = cyc;
      end else begin
        sclk = ~t_cpol;
        sdo = b;
        wait_clk(4);
        sclk = t_cpol;
        last_samp = cyc;
      end
      if (rdy_pulse && i == nsend - 1) begin
        wait_clk(1);
        ready = 1'b1;
        wait_clk(1);
        ready = 1'b0;
        wait_clk(2);
      end else begin
        wait_clk(4);
      end
      if (!t_cpha) sclk = t_cpol;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    send_bits(w, nbits(t_dff), nbits(t_dff), 1'b0);
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      wait_clk(1);
      k++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic set_cfg(input bit p, input bit h, input bit l,
                         input bit [1:0] d);
    t_cpol = p;
    t_cpha = h;
    t_lsb  = l;
    t_dff  = d;
    cfg_apply();
  endtask

  initial begin
    int ovf0, ferr0, pops0, exp_ferr;
    logic [31:0] w;
    cs_n = 1'b1; sclk = 1'b0; sdo = 1'b0;
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; dff = 2'd0;
    ready = 1'b0;
    rst = 1'b1;
    wait_clk(3);
    chk("rst_data", data, 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_ferr", 32'(ferr), 32'd0);
    rst = 1'b0;
    wait_clk(8);

    // 1: basic MSB-first byte and output latency
    set_cfg(0, 0, 0, 2'd0);
    cs_low();
    chk("t1_busy", 32'(busy), 32'd1);
    exp_q.push_back(model_word(32'hA5, 8));
    rise_cyc = -1;
    send_word(32'hA5);
    cs_high();
    chk("t1_latency", 32'(rise_cyc - last_samp), 32'd3);
    chk("t1_data", data, 32'h0000_00A5);
    chk("t1_valid", 32'(valid), 32'd1);
    ready = 1'b1;
    drain(50);
    ready = 1'b0;
    wait_clk(2);
    chk("t1_valid_clr", 32'(valid), 32'd0);

    // 2: cpol=1 cpha=1 LSB-first 32-bit; mid-frame cfg changes ignored
    set_cfg(1, 1, 1, 2'd3);
    ready = 1'b1;
    pops0 = pops;
    exp_q.push_back(model_word(32'h1234_5678, 32));
    cs_low();
    cpha = 1'b0; lsb = 1'b0; dff = 2'd0; cpol = 1'b0;
    send_word(32'h1234_5678);
    cs_high();
    drain(50);
    chk("t2_beats", 32'(pops - pops0), 32'd1);
    ready = 1'b0;

    // 3: overflow with full holding register
    set_cfg(0, 0, 0, 2'd1);
    ovf0 = ovf_seen;
    exp_q.push_back(model_word(32'h1111, 16));
    cs_low();
    send_word(32'h1111);
    send_word(32'h2222);
    cs_high();
    chk("t3_ovf", 32'(ovf_seen - ovf0), 32'd1);
    chk("t3_data", data, 32'h1111);
    chk("t3_valid", 32'(valid), 32'd1);
    ready = 1'b1;
    drain(50);
    ready = 1'b0;

    // 4: consume and load in the same cycle
    set_cfg(0, 0, 0, 2'd0);
    ovf0 = ovf_seen;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    cs_low();
    send_bits(32'h01, 8, 8, 1'b0);
    send_bits(32'h02, 8, 8, 1'b1);
    chk("t4_valid", 32'(valid), 32'd1);
    chk("t4_data", data, 32'h02);
    chk("t4_left", 32'(exp_q.size()), 32'd1);
    cs_high();
    chk("t4_ovf", 32'(ovf_seen - ovf0), 32'd0);
    ready = 1'b1;
    drain(50);
    ready = 1'b0;

    // 5: partial word, then a clean frame
    set_cfg(0, 0, 0, 2'd0);
    ferr0 = ferr_seen;
    cs_low();
    send_bits(32'hFF, 8, 5, 1'b0);
    cs_high();
    chk("t5_ferr", 32'(ferr_seen - ferr0), 32'd1);
    chk("t5_valid", 32'(valid), 32'd0);
    exp_q.push_back(model_word(32'h3C, 8));
    cs_low();
    send_word(32'h3C);
    cs_high();
    chk("t5_data", data, 32'h3C);
    ready = 1'b1;
    drain(50);
    ready = 1'b0;

    // 6: reset mid-frame, cs_n held low after release
    set_cfg(0, 0, 0, 2'd1);
    ferr0 = ferr_seen;
    cs_low();
    send_bits(32'hABCD, 16, 4, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_data", data, 32'd0);
    chk("t6_valid", 32'(valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ovf", 32'(ovf), 32'd0);
    chk("t6_ferr", 32'(ferr), 32'd0);
    wait_clk(2);
    rst = 1'b0;
    wait_clk(2);
    send_word(32'h5A5A);
    chk("t6_busy_ign", 32'(busy), 32'd0);
    cs_high();
    chk("t6_valid_ign", 32'(valid), 32'd0);
    chk("t6_ferr_ign", 32'(ferr_seen - ferr0), 32'd0);
    exp_q.push_back(model_word(32'hBEEF, 16));
    cs_low();
    send_word(32'hBEEF);
    cs_high();
    chk("t6_data_new", data, 32'hBEEF);
    ready = 1'b1;
    drain(50);

    // random frames, consumer always ready
    ovf0 = ovf_seen;
    ferr0 = ferr_seen;
    exp_ferr = 0;
    for (int f = 0; f < 20; f++) begin
      int nw;
      set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      cs_low();
      cpol = 1'($urandom); cpha = 1'($urandom);
      lsb = 1'($urandom); dff = 2'($urandom);
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) begin
        w = $urandom;
        exp_q.push_back(model_word(w, nbits(t_dff)));
        send_word(w);
      end
      if ($urandom_range(0, 3) == 0) begin
        send_bits($urandom, nbits(t_dff),
                  $urandom_range(1, nbits(t_dff) - 1), 1'b0);
        exp_ferr++;
      end
      cs_high();
    end
    drain(200);
    chk("rnd_ovf", 32'(ovf_seen - ovf0), 32'd0);
    chk("rnd_ferr", 32'(ferr_seen - ferr0), 32'(exp_ferr));
    ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
